pipe_register_skid: RTL

- Parametrised successor to the team's fixed-width enable/clear register: a WIDTH-bit pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Allows full-throughput streaming between pipeline stages with a registered in_ready, which breaks the combinational ready path.
- Sits between datapath stages such as fetch→decode and execute→writeback.
- Keeps the familiar output_enable gating and clear semantics.

---
 rtl/pipe_register_skid.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_register_skid.sv
// WIDTH-bit pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Optional output transfer counter port xfer_count enabled by macro PIPE_REG_XFER_COUNT_EN.
module pipe_register_skid #(
    parameter int WIDTH      = 64,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             output_enable
`ifdef PIPE_REG_XFER_COUNT_EN
    ,
    output logic [31:0]      xfer_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Handshake outputs decode registered state only, so in_ready never sees out_ready.
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_SKID);
    assign out_data  = output_enable ? r_main_data : '0;

    // State register; clear dominates everything else.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and data-register load strobes; flush drops both entries and any input.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        w_load_main = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (in_valid) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Main entry: refilled from skid first so the older item always leaves first.
    always_ff @(posedge clock) begin
        if (clear) begin
            if (CLEAR_DATA) begin
                r_main_data <= '0;
            end
        end else if (w_main_from_skid) begin
            r_main_data <= r_skid_data;
        end else if (w_load_main) begin
            r_main_data <= in_data;
        end
    end

    // Skid entry captures the input that arrived while the main entry was stalled.
    always_ff @(posedge clock) begin
        if (clear) begin
            if (CLEAR_DATA) begin
                r_skid_data <= '0;
            end
        end else if (w_load_skid) begin
            r_skid_data <= in_data;
        end
    end

`ifdef PIPE_REG_XFER_COUNT_EN
    logic        w_out_xfer;
    logic [31:0] r_xfer_count;

    assign w_out_xfer = out_valid & out_ready;
    assign xfer_count = r_xfer_count;

    // Output transfer counter; survives flush and counts a transfer in the flush cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_xfer_count <= '0;
        end else if (w_out_xfer) begin
            r_xfer_count <= r_xfer_count + 32'd1;
        end
    end
`endif

endmodule
